controller_regs_m: RTL

CPU-facing register block that sits directly downstream of `controller_interface_m`. Once per frame it drives that block's `start` input, waits a fixed number of `clk_1` cycles for the serial readout to finish, then snapshots both 8-bit controller words. It derives sticky "newly pressed" and "newly released" masks and exposes everything as eight read-only CPU registers, with clear-on-read for the sticky ones.

---
 rtl/controller_regs_m.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/controller_regs_m.sv
`timescale 1ns / 1ps
// controller_regs_m: polls controller_interface_m once per frame and presents the held,
// newly-pressed and newly-released button masks as eight read-only CPU registers.
module controller_regs_m #(
  parameter int unsigned START_CYCLES  = 9,
  parameter int unsigned SETTLE_CYCLES = 10
) (
  input  logic       clk_1,
  input  logic       rst,
  input  logic       frame_tick,
  output logic       ctrl_start,
  input  logic [7:0] controller_1_data_in,
  input  logic [7:0] controller_2_data_in,
  input  logic       cpu_read,
  input  logic [2:0] cpu_address,
  output logic [7:0] cpu_data_out,
  output logic       snapshot_valid,
  output logic       busy
);

  localparam int unsigned MaxCycles = (START_CYCLES > SETTLE_CYCLES) ? START_CYCLES
                                                                     : SETTLE_CYCLES;
  localparam int unsigned CntBits   = $clog2(MaxCycles + 1);
  localparam int unsigned CntW      = (CntBits > 5) ? CntBits : 5;

  localparam logic [CntW-1:0] StartLoad  = CntW'(START_CYCLES);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StSettle
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            capture;

  logic [7:0] held1_q, held1_d, held2_q, held2_d;
  logic [7:0] pressed1_q, pressed1_d, pressed2_q, pressed2_d;
  logic [7:0] released1_q, released1_d, released2_q, released2_d;
  logic       overrun_q, overrun_d;
  logic       ctrl_start_q, ctrl_start_d;
  logic       busy_q, busy_d;
  logic       snapshot_valid_q, snapshot_valid_d;

  // Poll sequencer: a count of N expires on the N-th edge after it is loaded, so START lasts
  // START_CYCLES cycles and the capture lands SETTLE_CYCLES edges after START ends.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_tick) begin
          state_d = StStart;
          cnt_d   = StartLoad;
        end
      end
      StStart: begin
        if (cnt_q == CntOne) begin
          state_d = StSettle;
          cnt_d   = SettleLoad;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StSettle: begin
        if (cnt_q == CntOne) begin
          state_d = StIdle;
          cnt_d   = '0;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Register file next state: clear-on-read is applied first so that bits set by a
  // coinciding capture survive the read.
  always_comb begin
    held1_d     = held1_q;
    held2_d     = held2_q;
    pressed1_d  = pressed1_q;
    pressed2_d  = pressed2_q;
    released1_d = released1_q;
    released2_d = released2_q;
    overrun_d   = overrun_q;

    if (cpu_read) begin
      unique case (cpu_address)
        3'd2:    pressed1_d  = '0;
        3'd3:    pressed2_d  = '0;
        3'd4:    released1_d = '0;
        3'd5:    released2_d = '0;
        3'd6:    overrun_d   = 1'b0;
        default: ;
      endcase
    end

    if (capture) begin
      held1_d     = controller_1_data_in;
      held2_d     = controller_2_data_in;
      pressed1_d  = pressed1_d  | (controller_1_data_in & ~held1_q);
      pressed2_d  = pressed2_d  | (controller_2_data_in & ~held2_q);
      released1_d = released1_d | (held1_q & ~controller_1_data_in);
      released2_d = released2_d | (held2_q & ~controller_2_data_in);
    end

    // A tick that arrives mid-poll is dropped but remembered.
    if (frame_tick && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    ctrl_start_d     = (state_d == StStart);
    busy_d           = (state_d != StIdle);
    snapshot_valid_d = capture;
  end

  // All state, including the registered outputs, with asynchronous reset.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      held1_q          <= '0;
      held2_q          <= '0;
      pressed1_q       <= '0;
      pressed2_q       <= '0;
      released1_q      <= '0;
      released2_q      <= '0;
      overrun_q        <= 1'b0;
      ctrl_start_q     <= 1'b0;
      busy_q           <= 1'b0;
      snapshot_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      held1_q          <= held1_d;
      held2_q          <= held2_d;
      pressed1_q       <= pressed1_d;
      pressed2_q       <= pressed2_d;
      released1_q      <= released1_d;
      released2_q      <= released2_d;
      overrun_q        <= overrun_d;
      ctrl_start_q     <= ctrl_start_d;
      busy_q           <= busy_d;
      snapshot_valid_q <= snapshot_valid_d;
    end
  end

  // Zero-latency read mux; reads return the pre-edge value.
  always_comb begin
    cpu_data_out = 8'h00;
    unique case (cpu_address)
      3'd0:    cpu_data_out = held1_q;
      3'd1:    cpu_data_out = held2_q;
      3'd2:    cpu_data_out = pressed1_q;
      3'd3:    cpu_data_out = pressed2_q;
      3'd4:    cpu_data_out = released1_q;
      3'd5:    cpu_data_out = released2_q;
      3'd6:    cpu_data_out = {6'b0, overrun_q, busy_q};
      default: cpu_data_out = 8'h00;
    endcase
  end

  assign ctrl_start     = ctrl_start_q;
  assign busy           = busy_q;
  assign snapshot_valid = snapshot_valid_q;

endmodule
